// File: rtl/rib_arb.sv
// RIB responder arbiter: m0 (core) / m1 (JTAG) -> NSLV slaves by addr[31:28], with ack timeout.
// Grant-to-select 1 cycle, slave ack -> master ack 1 cycle (min 2); core is held via hold_flag_o until its ack.
module rib_arb #(
    parameter int          NSLV     = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m0_addr_i,
    input  logic [31:0]          m0_data_i,
    input  logic                 m0_we_i,
    input  logic                 m0_req_i,
    output logic [31:0]          m0_data_o,
    output logic                 m0_ack_o,
    input  logic [31:0]          m1_addr_i,
    input  logic [31:0]          m1_data_i,
    input  logic                 m1_we_i,
    input  logic                 m1_req_i,
    output logic [31:0]          m1_data_o,
    output logic                 m1_ack_o,
    output logic                 hold_flag_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_data_o,
    output logic                 s_we_o,
    output logic [NSLV-1:0]      s_sel_o,
    input  logic [32*NSLV-1:0]   s_data_i,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic                 err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;       // 0 = m0, 1 = m1
    logic            r_fair;
    logic [3:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_gnt_m1;
    logic            w_grant;
    logic [3:0]      w_req_idx;
    logic            w_mapped;
    logic            w_slv_ack;
    logic [31:0]     w_slv_dat;
    logic            w_tout;

    // m1 wins unless m0 is also asking and is owed the next slot
    always_comb begin
        w_gnt_m1  = m1_req_i && !(m0_req_i && r_fair);
        w_grant   = w_gnt_m1 || m0_req_i;
        w_req_idx = w_gnt_m1 ? m1_addr_i[31:28] : m0_addr_i[31:28];
        w_mapped  = ({28'd0, w_req_idx} < 32'(NSLV));
        w_tout    = (r_cnt == CW'(TIMEOUT - 1));
    end

    always_comb begin
        w_slv_ack = 1'b0;
        w_slv_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_idx == 4'(k)) begin
                w_slv_ack = s_ack_i[k];
                w_slv_dat = s_data_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        s_sel_o     = '0;
        m0_ack_o    = 1'b0;
        m1_ack_o    = 1'b0;
        m0_data_o   = '0;
        m1_data_o   = '0;
        err_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_nxt = w_mapped ? ST_BUSY : ST_RESP;
            end
            ST_BUSY: begin
                for (int k = 0; k < NSLV; k++) s_sel_o[k] = (r_idx == 4'(k));
                if (w_slv_ack || w_tout) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                m0_ack_o    = !r_owner;
                m1_ack_o    = r_owner;
                m0_data_o   = r_owner ? '0 : r_rdata;
                m1_data_o   = r_owner ? r_rdata : '0;
                err_o       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= 1'b0;
            r_fair   <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            s_addr_o <= '0;
            s_data_o <= '0;
            s_we_o   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_gnt_m1;
                        s_addr_o <= w_gnt_m1 ? m1_addr_i : m0_addr_i;
                        s_data_o <= w_gnt_m1 ? m1_data_i : m0_data_i;
                        s_we_o   <= w_gnt_m1 ? m1_we_i   : m0_we_i;
                        r_idx    <= w_req_idx;
                        r_cnt    <= '0;
                        r_rdata  <= ERR_DATA;
                        r_err    <= !w_mapped;
                        if (w_gnt_m1 && m0_req_i) r_fair <= 1'b1;
                        else if (!w_gnt_m1)       r_fair <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_slv_ack) begin
                        r_rdata <= w_slv_dat;
                        r_err   <= 1'b0;
                    end else if (w_tout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hold_flag_o = (m0_req_i && !m0_ack_o) || ((r_state != ST_IDLE) && r_owner);

endmodule

// File: tb/tb_rib_arb.sv
// Bench for rib_arb: directed masters, a delay-programmable slave model and an in-order response scoreboard.
module tb_rib_arb;

    localparam int NSLV = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
    logic                m0_we_i, m0_req_i, m1_we_i, m1_req_i;
    logic [31:0]         m0_data_o, m1_data_o;
    logic                m0_ack_o, m1_ack_o, hold_flag_o, s_we_o, err_o;
    logic [31:0]         s_addr_o, s_data_o;
    logic [NSLV-1:0]     s_sel_o, s_ack_i;
    logic [32*NSLV-1:0]  s_data_i;

    always #5 clk = ~clk;

    rib_arb #(.NSLV(NSLV), .TIMEOUT(255), .ERR_DATA(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_req_i(m0_req_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_req_i(m1_req_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .hold_flag_o(hold_flag_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .err_o(err_o)
    );

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        chk_dat;
        logic        err;
    } sb_t;

    sb_t             sb_q[$];
    int              n_vec = 0;
    int              n_mis = 0;
    int              slv_dly[NSLV];
    logic [31:0]     slv_dat[NSLV];
    logic [NSLV-1:0] stray;
    int              sel_cnt;
    logic            pend0, pend1;
    int              lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic [31:0] d, input logic cd, input logic e);
        sb_t s;
        s.owner = own; s.data = d; s.chk_dat = cd; s.err = e;
        sb_q.push_back(s);
    endtask

    task automatic request(input int m, input logic [31:0] a, input logic [31:0] d, input logic we);
        if (m == 0) begin
            m0_addr_i = a; m0_data_i = d; m0_we_i = we; m0_req_i = 1'b1; pend0 = 1'b0;
        end else begin
            m1_addr_i = a; m1_data_i = d; m1_we_i = we; m1_req_i = 1'b1; pend1 = 1'b0;
        end
    endtask

    // one clock: masters drop req after their ack, outputs checked at negedge, slaves respond
    task automatic step();
        sb_t             e;
        logic [NSLV-1:0] ack;
        if (pend0) begin m0_req_i = 1'b0; pend0 = 1'b0; end
        if (pend1) begin m1_req_i = 1'b0; pend1 = 1'b0; end
        @(negedge clk);
        if (m0_ack_o || m1_ack_o) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_owner_m0", m0_ack_o, !e.owner);
                chk("sb_owner_m1", m1_ack_o, e.owner);
                if (e.chk_dat) chk("sb_rdata", e.owner ? m1_data_o : m0_data_o, e.data);
                chk("sb_err", err_o, e.err);
            end
            if (m0_ack_o) pend0 = 1'b1;
            if (m1_ack_o) pend1 = 1'b1;
        end else begin
            chk("err_without_ack", err_o, 0);
        end
        if (!m0_ack_o) chk("m0_dat_idle", m0_data_o, 0);
        if (!m1_ack_o) chk("m1_dat_idle", m1_data_o, 0);
        ack = '0;
        if (s_sel_o != '0) begin
            for (int k = 0; k < NSLV; k++)
                if (s_sel_o[k] && sel_cnt == slv_dly[k]) ack[k] = 1'b1;
            sel_cnt++;
        end else begin
            sel_cnt = 0;
        end
        s_ack_i = ack | stray;
        for (int k = 0; k < NSLV; k++) s_data_i[32*k +: 32] = slv_dat[k];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   s_sel_o, 0);
        chk({tag, "_saddr"}, s_addr_o, 0);
        chk({tag, "_sdata"}, s_data_o, 0);
        chk({tag, "_swe"},   s_we_o, 0);
        chk({tag, "_ack0"},  m0_ack_o, 0);
        chk({tag, "_ack1"},  m1_ack_o, 0);
        chk({tag, "_dat0"},  m0_data_o, 0);
        chk({tag, "_dat1"},  m1_data_o, 0);
        chk({tag, "_err"},   err_o, 0);
        chk({tag, "_hold"},  hold_flag_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        m0_addr_i = '0; m0_data_i = '0; m0_we_i = 1'b0; m0_req_i = 1'b0;
        m1_addr_i = '0; m1_data_i = '0; m1_we_i = 1'b0; m1_req_i = 1'b0;
        s_ack_i = '0; s_data_i = '0; stray = '0; sel_cnt = 0; pend0 = 1'b0; pend1 = 1'b0;
        for (int k = 0; k < NSLV; k++) begin
            slv_dly[k] = -1;
            slv_dat[k] = 32'hA5A5_0000 | 32'(k);
        end

        // reset state
        step(); step();
        chk_all_zero("rst");
        rst = 1'b1;
        step();

        // m0 write to slave1, ack 3 cycles after select
        slv_dly[1] = 3;
        request(0, 32'h1000_0010, 32'h1234_5678, 1'b1);
        push(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("t1_hold_n", hold_flag_o, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t1_ack", m0_ack_o, 32'(k == 5));
            if (k <= 4) begin
                chk("t1_hold", hold_flag_o, 1);
                chk("t1_sel", s_sel_o, 4'b0010);
                chk("t1_we", s_we_o, 1);
                chk("t1_sdata", s_data_o, 32'h1234_5678);
                chk("t1_saddr", s_addr_o, 32'h1000_0010);
            end else begin
                chk("t1_hold_end", hold_flag_o, 0);
                chk("t1_sel_end", s_sel_o, 0);
            end
        end
        step(); step();

        // m0 read from slave2, ack on first BUSY cycle
        slv_dly[2] = 0;
        slv_dat[2] = 32'hCAFE_BABE;
        request(0, 32'h2000_0000, 32'h0, 1'b0);
        push(1'b0, 32'hCAFE_BABE, 1'b1, 1'b0);
        step();
        chk("t2_sel", s_sel_o, 4'b0100);
        chk("t2_we", s_we_o, 0);
        chk("t2_ack_early", m0_ack_o, 0);
        step();
        chk("t2_ack", m0_ack_o, 1);
        chk("t2_data", m0_data_o, 32'hCAFE_BABE);
        chk("t2_err", err_o, 0);
        step(); step();

        // contention: m1 first, then m0 despite m1 re-requesting at once
        slv_dly[1] = 1; slv_dat[1] = 32'h1111_1111;
        slv_dly[2] = 2; slv_dat[2] = 32'h2222_2222;
        request(0, 32'h1000_0000, 32'h0, 1'b0);
        request(1, 32'h2000_0004, 32'h0, 1'b0);
        push(1'b1, 32'h2222_2222, 1'b1, 1'b0);
        push(1'b0, 32'h1111_1111, 1'b1, 1'b0);
        push(1'b1, 32'h2222_2222, 1'b1, 1'b0);
        #1 chk("t3_hold_n", hold_flag_o, 1);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("t3_m0_ack", m0_ack_o, 32'(k == 8));
            chk("t3_m1_ack", m1_ack_o, 32'(k == 4 || k == 13));
            if (k <= 8) chk("t3_hold", hold_flag_o, 32'(k <= 7));
            if (k == 4) request(1, 32'h2000_0004, 32'h0, 1'b0);
        end
        step(); step();

        // slave0 never acks (stray ack on unselected slave1): timeout after 255 BUSY cycles
        slv_dly[0] = -1;
        stray = 4'b0010;
        request(0, 32'h0000_0000, 32'h0, 1'b0);
        push(1'b0, 32'h0000_0000, 1'b1, 1'b1);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (m0_ack_o && lat == 0) begin
                lat = k;
                chk("t4_err", err_o, 1);
                chk("t4_data", m0_data_o, 32'h0);
            end
        end
        chk("t4_latency", lat, 256);
        stray = '0;
        step(); step();

        // unmapped accesses: m1 at idx 15, m0 at idx == NSLV
        request(1, 32'hF000_0000, 32'h0, 1'b0);
        push(1'b1, 32'h0, 1'b1, 1'b1);
        #1 chk("t5_sel_n", s_sel_o, 0);
        step();
        chk("t5_sel", s_sel_o, 0);
        chk("t5_ack", m1_ack_o, 1);
        chk("t5_err", err_o, 1);
        chk("t5_data", m1_data_o, 32'h0);
        step();
        chk("t5_ack_gone", m1_ack_o, 0);
        step();
        request(0, 32'h4000_0000, 32'h0, 1'b0);
        push(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        chk("t5b_ack", m0_ack_o, 1);
        chk("t5b_err", err_o, 1);
        step(); step();

        // owner drops req mid-transaction: ack still arrives
        slv_dly[2] = 2; slv_dat[2] = 32'h5A5A_5A5A;
        request(0, 32'h2000_0008, 32'h0, 1'b0);
        push(1'b0, 32'h5A5A_5A5A, 1'b1, 1'b0);
        step();
        m0_req_i = 1'b0;
        lat = 0;
        for (int k = 2; k <= 10; k++) begin
            step();
            if (m0_ack_o && lat == 0) lat = k;
        end
        chk("tdrop_latency", lat, 4);

        // reset during BUSY abandons the transaction
        slv_dly[3] = 5; slv_dat[3] = 32'h3333_3333;
        request(0, 32'h3000_0000, 32'hDEAD_BEEF, 1'b1);
        step();
        chk("t6_sel", s_sel_o, 4'b1000);
        step();
        m0_req_i = 1'b0;
        rst = 1'b0;
        #1 chk_all_zero("t6");
        step(); step(); step();
        rst = 1'b1;
        step();
        slv_dly[3] = 1;
        request(0, 32'h3000_0004, 32'h0, 1'b0);
        push(1'b0, 32'h3333_3333, 1'b1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (m0_ack_o && lat == 0) lat = k;
        end
        chk("t6_after_latency", lat, 3);

        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/rib_arb.md
Name: rib_arb

Overview:
- Responder-side interconnect for the RIB data bus.
- Accepts requests from two masters: m0 is the core data port (ex stage), m1 is the JTAG debug master.
- Arbitrates between them, decodes the target slave from the address, and waits for the slave's acknowledge, with a timeout.
- Returns a registered one-cycle ack to the winning master and drives the hold flag back to the core while its access is outstanding.

Parameters:
- NSLV, 4, number of slave ports; slave index = addr[31:28]; indices >= NSLV are unmapped.
- TIMEOUT, 255, maximum number of BUSY cycles waiting for a slave ack before an error response.
- ERR_DATA, 32'h0000_0000, read data returned on timeout or unmapped access.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m0_addr_i  in  32  core access address
- m0_data_i  in  32  core write data
- m0_we_i  in  1  core write enable
- m0_req_i  in  1  core request; held high until m0_ack_o
- m0_data_o  out  32  read data to core; valid while m0_ack_o=1
- m0_ack_o  out  1  one-cycle completion pulse to core
- m1_addr_i  in  32  JTAG access address
- m1_data_i  in  32  JTAG write data
- m1_we_i  in  1  JTAG write enable
- m1_req_i  in  1  JTAG request; held high until m1_ack_o
- m1_data_o  out  32  read data to JTAG; valid while m1_ack_o=1
- m1_ack_o  out  1  one-cycle completion pulse to JTAG
- hold_flag_o  out  1  pipeline hold to core (feeds rib_hold_flag_i)
- s_addr_o  out  32  latched address, shared by all slaves
- s_data_o  out  32  latched write data, shared by all slaves
- s_we_o  out  1  latched write enable
- s_sel_o  out  NSLV  one-hot slave select, asserted in BUSY only
- s_data_i  in  32*NSLV  slave read data, slave k on bits [32k+31:32k]
- s_ack_i  in  NSLV  slave acknowledge, one bit per slave
- err_o  out  1  one-cycle pulse on timeout or unmapped access

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; owner=m0; fair=0; counter=0.
  - All outputs 0: data outputs, acks, s_sel_o, s_addr_o, s_data_o, s_we_o, err_o.
  - A transaction in progress is abandoned with no ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Arbitration: if m1_req_i && !(m0_req_i && fair), grant m1; else if m0_req_i, grant m0.
  - On grant: latch addr, data and we into s_* registers; record owner; latch idx=addr[31:28]; clear counter.
  - If idx >= NSLV: go to RESP with rdata=ERR_DATA and err pending; no slave is selected.
  - Otherwise go to BUSY.
- BUSY:
  - s_sel_o[idx]=1; counter increments each cycle.
  - If s_ack_i[idx]=1: capture the s_data_i slice idx into rdata; go to RESP.
  - Else if counter==TIMEOUT-1: rdata=ERR_DATA, err pending; go to RESP; the slave is deselected.
  - Acks from non-selected slaves are ignored.
- RESP:
  - s_sel_o=0; the owner's ack_o=1 and data_o=rdata (data_o meaningful only for reads).
  - err_o=1 if err pending.
  - Next state IDLE.
- Master outputs outside RESP: data_o and ack_o are 0 for both masters.
- Latency and throughput:
  - Request seen in IDLE at cycle N; s_sel_o asserted at N+1.
  - Slave ack at N+1+k gives master ack at N+2+k; minimum 2 cycles.
  - One transaction per 3 cycles maximum.
- Fairness: fair is set when m1 is granted while m0_req_i=1; it is cleared when m0 is granted. This guarantees m0 the next grant after a contended m1 access.
- Dropped request: if the owner drops req mid-transaction, the transaction still completes and ack still pulses.
- hold_flag_o = (m0_req_i && !m0_ack_o) || (state!=IDLE && owner==m1). This output is combinational.
- Writes: the slave sees s_we_o=1 for the whole BUSY period. The returned data_o on writes is rdata, which is don't-care.

Test Plan:
- m0 writes 0x1234_5678 to 0x1000_0010; slave1 acks 3 cycles after sel. Required: s_sel_o=4'b0010, s_we_o=1, s_data_o=0x12345678; m0_ack_o pulses at N+5; hold_flag_o=1 for cycles N..N+4.
- m0 reads 0x2000_0000; slave2 acks on the first BUSY cycle with 0xCAFEBABE. Required: m0_ack_o at N+2 with m0_data_o=0xCAFEBABE; err_o=0.
- m0 and m1 request together in IDLE. Required: m1 is served first, hold_flag_o=1 throughout; m0 is served next even though m1 re-requests immediately.
- m0 reads 0x0000_0000; slave0 never acks, TIMEOUT=255. Required: m0_ack_o 256 cycles after the request with m0_data_o=ERR_DATA and err_o pulsing in the same cycle.
- m1 reads unmapped address 0xF000_0000. Required: s_sel_o stays 0; m1_ack_o and err_o pulse at N+1; m1_data_o=ERR_DATA.
- Assert rst low during BUSY. Required: all outputs go to 0 immediately, no ack is issued, and after release a new m0 request completes normally.
